// File: rtl/intr_ctrl.sv
// Fixed-priority interrupt controller: per-line edge latching, vector redirect,
// EPC save and banked-flag select for a single non-nesting service routine.

module intr_ctrl_lane (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  logic irq_q, irq_d;
  logic pend_q, pend_d;

  // A fresh edge beats a same-cycle clear so no request is ever dropped.
  always_comb begin
    irq_d  = irq;
    pend_d = (pend_q & ~clr) | (irq & ~irq_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      irq_q  <= irq_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
endmodule

module intr_ctrl #(
  parameter int                  N_IRQ      = 4,
  parameter int                  PC_WIDTH   = 10,
  parameter logic [PC_WIDTH-1:0] VEC_BASE   = 'h3C0,
  parameter int                  VEC_STRIDE = 4,
  localparam int                 ID_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_IRQ-1:0]    irq,
  input  logic                mask_we,
  input  logic [N_IRQ-1:0]    mask_in,
  input  logic [PC_WIDTH-1:0] pc_next,
  input  logic                reti,
  output logic                take_intr,
  output logic [PC_WIDTH-1:0] vector_addr,
  output logic                do_ret,
  output logic [PC_WIDTH-1:0] ret_addr,
  output logic                interruption,
  output logic [ID_W-1:0]     active_id,
  output logic [N_IRQ-1:0]    pending,
  output logic                bad_ret
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ENTER   = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;
  localparam logic [1:0] RETURN  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [N_IRQ-1:0]    mask_q, mask_d;
  logic [PC_WIDTH-1:0] epc_q, epc_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [N_IRQ-1:0]    pend, req, clr;
  logic [ID_W-1:0]     sel_id;

  intr_ctrl_lane u_lane [N_IRQ-1:0] (
    .clk  (clk),
    .reset(reset),
    .irq  (irq),
    .clr  (clr),
    .pend (pend)
  );

  always_comb begin
    req    = pend & mask_q;
    sel_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (req[i]) sel_id = ID_W'(i);

    state_d = state_q;
    epc_d   = epc_q;
    id_d    = id_q;
    clr     = '0;
    // Mask writes land after this cycle's arbitration, which sees the old mask.
    mask_d  = mask_we ? mask_in : mask_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d     = ENTER;
        id_d        = sel_id;
        epc_d       = pc_next;
        clr[sel_id] = 1'b1;
      end
      ENTER:   state_d = SERVICE;
      SERVICE: if (reti) state_d = RETURN;
      // RETURN skips arbitration so one main-program instruction always runs.
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      epc_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      epc_q   <= epc_d;
      id_q    <= id_d;
    end
  end

  assign take_intr    = (state_q == ENTER);
  assign interruption = (state_q == ENTER) || (state_q == SERVICE);
  assign do_ret       = (state_q == SERVICE) && reti;
  assign bad_ret      = reti && (state_q != SERVICE);
  assign vector_addr  = VEC_BASE + PC_WIDTH'(id_q) * PC_WIDTH'(VEC_STRIDE);
  assign ret_addr     = epc_q;
  assign active_id    = id_q;
  assign pending      = pend;
endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios plus random traffic against a
// transaction-level model of the service routine.

module tb_intr_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq, mask_in, pending;
  logic       mask_we, reti, take_intr, do_ret, interruption, bad_ret;
  logic [9:0] pc_next, vector_addr, ret_addr;
  logic [1:0] active_id;

  int total = 0;
  int bad   = 0;

  intr_ctrl dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .pc_next(pc_next), .reti(reti), .take_intr(take_intr), .vector_addr(vector_addr),
    .do_ret(do_ret), .ret_addr(ret_addr), .interruption(interruption),
    .active_id(active_id), .pending(pending), .bad_ret(bad_ret)
  );

  always #5 clk = ~clk;

  // Model: a routine is "in_rtn" from the vector fetch until reti is accepted;
  // "first" marks the vector-fetch cycle, "gap" the one forced main-program cycle.
  logic [3:0] m_pend, m_mask, m_prev, m_en;
  logic [9:0] m_epc;
  logic [1:0] m_id;
  logic       m_in_rtn, m_first, m_gap;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_epc = 0; m_id = 0;
      m_in_rtn = 0; m_first = 0; m_gap = 0;
    end else begin
      if (m_gap) m_gap = 0;
      else if (!m_in_rtn) begin
        m_en = m_pend & m_mask;
        if (m_en != 0) begin
          for (int i = 3; i >= 0; i--) if (m_en[i]) m_id = 2'(i);
          m_pend[m_id] = 1'b0;
          m_epc = pc_next;
          m_in_rtn = 1; m_first = 1;
        end
      end else if (m_first) m_first = 0;
      else if (reti) begin m_in_rtn = 0; m_gap = 1; end
      m_pend = m_pend | (irq & ~m_prev);
      if (mask_we) m_mask = mask_in;
      m_prev = irq;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_mask(input logic [3:0] m);
    mask_in = m; mask_we = 1; tick(); mask_we = 0;
  endtask

  task automatic test_reset();
    reset = 0; irq = 0; mask_we = 0; mask_in = 0; pc_next = 0; reti = 0;
    tick(); tick();
    @(negedge clk);
    total++;
    if ({take_intr, interruption, do_ret, bad_ret, pending, active_id, ret_addr} !== 21'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0",
        {take_intr, interruption, do_ret, bad_ret, pending, active_id, ret_addr});
    end
    total++;
    if (vector_addr !== 10'h3C0) begin bad++; $display("FAIL reset_vector got=%h exp=3c0", vector_addr); end
    @(posedge clk); #1 reset = 1;
  endtask

  task automatic test_single();
    set_mask(4'b0010);
    irq = 4'b0010; pc_next = 10'h025; tick(); irq = 0;
    @(negedge clk);
    total++;
    if (pending !== 4'b0010 || take_intr !== 1'b0) begin
      bad++; $display("FAIL single_pend got=%b/%b exp=0010/0", pending, take_intr);
    end
    tick();
    @(negedge clk);
    total++;
    if ({take_intr, interruption, vector_addr} !== {2'b11, 10'h3C4}) begin
      bad++; $display("FAIL single_take got=%b%b/%h exp=11/3c4", take_intr, interruption, vector_addr);
    end
    tick(); reti = 1;
    @(negedge clk);
    total++;
    if ({do_ret, ret_addr, interruption, take_intr} !== {1'b1, 10'h025, 2'b10}) begin
      bad++; $display("FAIL single_ret got=%b/%h/%b%b exp=1/025/10", do_ret, ret_addr, interruption, take_intr);
    end
    tick(); reti = 0;
    @(negedge clk);
    total++;
    if (interruption !== 1'b0 || do_ret !== 1'b0) begin
      bad++; $display("FAIL single_after got=%b%b exp=00", interruption, do_ret);
    end
    tick();
  endtask

  task automatic test_priority();
    set_mask(4'hF);
    irq = 4'b1001; tick(); irq = 0; tick();
    @(negedge clk);
    total++;
    if ({take_intr, vector_addr, pending} !== {1'b1, 10'h3C0, 4'b1000}) begin
      bad++; $display("FAIL prio_first got=%b/%h/%b exp=1/3c0/1000", take_intr, vector_addr, pending);
    end
    tick(); reti = 1; tick(); reti = 0;
    @(negedge clk);
    total++;
    if (take_intr !== 1'b0) begin bad++; $display("FAIL prio_return_cycle got=%b exp=0", take_intr); end
    tick();
    @(negedge clk);
    total++;
    if (take_intr !== 1'b0) begin bad++; $display("FAIL prio_idle_cycle got=%b exp=0", take_intr); end
    tick();
    @(negedge clk);
    total++;
    if ({take_intr, vector_addr, active_id, pending} !== {1'b1, 10'h3CC, 2'd3, 4'b0000}) begin
      bad++; $display("FAIL prio_second got=%b/%h/%0d/%b exp=1/3cc/3/0000", take_intr, vector_addr, active_id, pending);
    end
    tick(); reti = 1; tick(); reti = 0; tick();
  endtask

  task automatic test_mask();
    set_mask(4'b0000);
    irq = 4'b0100; tick(); irq = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (pending !== 4'b0100 || take_intr !== 1'b0) begin
        bad++; $display("FAIL mask_hold got=%b/%b exp=0100/0", pending, take_intr);
      end
      tick();
    end
    mask_in = 4'b0100; mask_we = 1;
    @(negedge clk);
    total++;
    if (take_intr !== 1'b0) begin bad++; $display("FAIL mask_write_cycle got=%b exp=0", take_intr); end
    tick(); mask_we = 0;
    @(negedge clk);
    total++;
    if (take_intr !== 1'b0) begin bad++; $display("FAIL mask_first_after got=%b exp=0", take_intr); end
    tick();
    @(negedge clk);
    total++;
    if (take_intr !== 1'b1 || vector_addr !== 10'h3C8) begin
      bad++; $display("FAIL mask_take got=%b/%h exp=1/3c8", take_intr, vector_addr);
    end
    tick(); reti = 1; tick(); reti = 0; tick();
  endtask

  task automatic test_level();
    int takes = 0;
    set_mask(4'hF);
    for (int c = 0; c < 30; c++) begin
      irq  = (c < 20) ? 4'b0010 : 4'b0000;
      reti = m_in_rtn && !m_first;
      @(negedge clk);
      if (take_intr) takes++;
      tick();
    end
    reti = 0;
    total++;
    if (takes != 1) begin bad++; $display("FAIL level_services got=%0d exp=1", takes); end
    @(negedge clk);
    total++;
    if (pending !== 4'b0000 || interruption !== 1'b0) begin
      bad++; $display("FAIL level_end got=%b/%b exp=0000/0", pending, interruption);
    end
  endtask

  task automatic test_spurious();
    tick(); reti = 1;
    @(negedge clk);
    total++;
    if (bad_ret !== 1'b1 || do_ret !== 1'b0) begin
      bad++; $display("FAIL spur_pulse got=%b/%b exp=1/0", bad_ret, do_ret);
    end
    tick(); reti = 0;
    @(negedge clk);
    total++;
    if ({bad_ret, interruption, take_intr} !== 3'b000) begin
      bad++; $display("FAIL spur_after got=%b exp=000", {bad_ret, interruption, take_intr});
    end
    tick();
    @(negedge clk);
    total++;
    if (take_intr !== 1'b0) begin bad++; $display("FAIL spur_still_idle got=%b exp=0", take_intr); end
  endtask

  task automatic test_reset_mid();
    tick();
    set_mask(4'hF);
    irq = 4'b0001; tick(); irq = 0; tick();
    irq = 4'b0100; tick(); irq = 0;
    @(negedge clk);
    total++;
    if (interruption !== 1'b1 || pending !== 4'b0100) begin
      bad++; $display("FAIL rstmid_pre got=%b/%b exp=1/0100", interruption, pending);
    end
    #2 reset = 0;
    #1;
    total++;
    if ({interruption, take_intr, pending} !== 6'd0) begin
      bad++; $display("FAIL rstmid_async got=%b exp=000000", {interruption, take_intr, pending});
    end
    @(posedge clk); #1 reset = 1;
    set_mask(4'b0001);
    irq = 4'b0001; tick(); irq = 0; tick();
    @(negedge clk);
    total++;
    if (take_intr !== 1'b1 || vector_addr !== 10'h3C0) begin
      bad++; $display("FAIL rstmid_again got=%b/%h exp=1/3c0", take_intr, vector_addr);
    end
    tick(); reti = 1; tick(); reti = 0; tick();
  endtask

  task automatic test_random();
    logic [9:0] e_vec;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) irq[b] = ~irq[b];
      mask_we = ($urandom_range(9) == 0);
      mask_in = 4'($urandom);
      pc_next = 10'($urandom);
      reti    = (m_in_rtn && !m_first) ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
      @(negedge clk);
      e_vec = 10'h3C0 + {8'd0, m_id} * 10'd4;
      total++;
      if ({take_intr, interruption, do_ret, bad_ret} !==
          {m_first, m_in_rtn, m_in_rtn && !m_first && reti, reti && !(m_in_rtn && !m_first)}) begin
        bad++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", c, {take_intr, interruption, do_ret, bad_ret},
          {m_first, m_in_rtn, m_in_rtn && !m_first && reti, reti && !(m_in_rtn && !m_first)});
      end
      total++;
      if ({pending, active_id, ret_addr, vector_addr} !== {m_pend, m_id, m_epc, e_vec}) begin
        bad++; $display("FAIL rand_data cyc=%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", c,
          pending, active_id, ret_addr, vector_addr, m_pend, m_id, m_epc, e_vec);
      end
      tick();
    end
    irq = 0; mask_we = 0; reti = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_level();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
